// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and helpers for the memory-access stage.
//   funct3_e : RISC-V load/store size/sign codes
//   state_e  : stage FSM states
//   be_w_of / ofs_w_of : width-derived constants (byte lanes, lane-offset bits)
//   funct3_legal : legal size code check for a load or store
package mem_stage_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_D  = 3'b011,
        F3_BU = 3'b100,
        F3_HU = 3'b101,
        F3_WU = 3'b110
    } funct3_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Number of byte lanes on the data bus.
    function automatic int be_w_of(int xlen);
        return xlen / 8;
    endfunction

    // Bits of the byte address that select a lane.
    function automatic int ofs_w_of(int xlen);
        return $clog2(xlen / 8);
    endfunction

    // wide = 1 when the datapath is 64 bits (enables LD/LWU/SD).
    function automatic logic funct3_legal(logic is_load, logic [2:0] f3, logic wide);
        logic ok;
        ok = 1'b0;
        if (is_load) begin
            case (f3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
                F3_D, F3_WU:                    ok = wide;
                default:                        ok = 1'b0;
            endcase
        end else begin
            case (f3)
                F3_B, F3_H, F3_W: ok = 1'b1;
                F3_D:             ok = wide;
                default:          ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering for the memory stage.
//   Store side: st_f3/st_ofs/st_data -> be (size mask shifted to the lane
//               offset) and wdata (store data replicated across all lanes).
//   Load side : ld_f3/ld_ofs/rdata   -> ld_data (selected lane, sign- or
//               zero-extended to XLEN).
module lsu_lane_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]                  st_f3,
    input  logic [ofs_w_of(XLEN)-1:0]   st_ofs,
    input  logic [XLEN-1:0]             st_data,
    output logic [XLEN/8-1:0]           be,
    output logic [XLEN-1:0]             wdata,
    input  logic [2:0]                  ld_f3,
    input  logic [ofs_w_of(XLEN)-1:0]   ld_ofs,
    input  logic [XLEN-1:0]             rdata,
    output logic [XLEN-1:0]             ld_data
);

    localparam int BE_W = be_w_of(XLEN);

    logic [3:0] st_size;
    assign st_size = 4'd1 << st_f3[1:0];

    // Per-lane steering: lane i enabled when it falls inside [ofs, ofs+size),
    // and carries byte (i mod size) of the store data.
    for (genvar i = 0; i < BE_W; i++) begin : g_lane
        assign be[i] = (i >= int'(st_ofs)) && (i < int'(st_ofs) + int'(st_size));

        always_comb begin
            case (st_f3[1:0])
                2'b00:   wdata[8*i +: 8] = st_data[7:0];
                2'b01:   wdata[8*i +: 8] = st_data[8*(i % 2) +: 8];
                2'b10:   wdata[8*i +: 8] = st_data[8*(i % 4) +: 8];
                default: wdata[8*i +: 8] = st_data[8*i +: 8];
            endcase
        end
    end

    // Shift the addressed lane down to bit 0, then extend by size/sign code.
    logic [XLEN-1:0] sh;
    assign sh = rdata >> {ld_ofs, 3'b000};

    always_comb begin
        case (ld_f3)
            F3_B:    ld_data = XLEN'($signed(sh[7:0]));
            F3_H:    ld_data = XLEN'($signed(sh[15:0]));
            F3_W:    ld_data = XLEN'($signed(sh[31:0]));
            F3_BU:   ld_data = XLEN'(sh[7:0]);
            F3_HU:   ld_data = XLEN'(sh[15:0]);
            F3_WU:   ld_data = XLEN'(sh[31:0]);
            default: ld_data = sh;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-access pipeline stage between execute and writeback.
// Accepts one load/store/non-memory op per handshake, drives a req/ack data
// bus with arbitrary wait states, and registers lmd (formatted load data) and
// condpc (next PC) for writeback.
//
// Ports:
//   clk, rst_n          clock; reset is asynchronous and active-high (rst_n=1 resets)
//   ex_*                op from execute (valid/ready handshake, ready only in IDLE)
//   dmem_*              data-memory bus (req held stable until ack)
//   wb_valid            one-cycle result pulse; misalign/bus_err valid with it
//   lmd, condpc         registered load data and next PC
//
// Optional feature: define MEM_TIMEOUT_EN to abort a BUSY access after
// TIMEOUT_CYCLES cycles without ack (reports bus_err). Undefined: BUSY waits
// indefinitely and bus_err stays 0.
module mem_stage_lsu
    import mem_stage_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_is_load,
    input  logic              ex_is_store,
    input  logic [2:0]        ex_funct3,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [XLEN-1:0]   ex_wdata,
    input  logic              ex_cond,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic [ADDR_W-1:0] ex_npc,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN/8-1:0] dmem_be,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_ack,
    output logic              wb_valid,
    output logic [XLEN-1:0]   lmd,
    output logic [ADDR_W-1:0] condpc,
    output logic              misalign,
    output logic              bus_err
);

    localparam int BE_W  = be_w_of(XLEN);
    localparam int OFS_W = ofs_w_of(XLEN);
    localparam logic WIDE = (XLEN == 64);

    state_e state, state_nxt;

    logic             accept;
    logic             is_mem;
    logic             bad;
    logic [OFS_W-1:0] ofs;
    logic [3:0]       acc_size;
    logic             tmo_hit;

    // Load context captured at request time for extraction on ack.
    logic             ld_q;
    logic [2:0]       ld_f3_q;
    logic [OFS_W-1:0] ld_ofs_q;

    logic [BE_W-1:0]  be_c;
    logic [XLEN-1:0]  wdata_c;
    logic [XLEN-1:0]  ld_data_c;

    assign accept   = ex_valid && ex_ready;
    assign is_mem   = ex_is_load || ex_is_store;
    assign ofs      = ex_addr[OFS_W-1:0];
    assign acc_size = 4'd1 << ex_funct3[1:0];
    // Misaligned covers both an address off the access size and an illegal code.
    assign bad      = (|(4'(ofs) & (acc_size - 4'd1))) ||
                      !funct3_legal(ex_is_load, ex_funct3, WIDE);

    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .st_f3   (ex_funct3),
        .st_ofs  (ofs),
        .st_data (ex_wdata),
        .be      (be_c),
        .wdata   (wdata_c),
        .ld_f3   (ld_f3_q),
        .ld_ofs  (ld_ofs_q),
        .rdata   (dmem_rdata),
        .ld_data (ld_data_c)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    // Ack wins over a timeout landing in the same cycle.
    assign tmo_hit = (state == BUSY) && !dmem_ack && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            tmo_cnt <= '0;
        else if (state != BUSY || dmem_ack || tmo_hit)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
`endif

    // FSM: state register
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && is_mem && !bad) state_nxt = BUSY;
            BUSY: if (dmem_ack || tmo_hit)      state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ex_ready = (state == IDLE);
    end

    // Registered bus outputs and writeback results.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_be    <= '0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            wb_valid   <= 1'b0;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
            lmd        <= '1;
            condpc     <= '0;
            ld_q       <= 1'b0;
            ld_f3_q    <= '0;
            ld_ofs_q   <= '0;
        end else begin
            wb_valid <= 1'b0;
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        condpc <= ex_cond ? ex_target : ex_npc;
                        if (is_mem && !bad) begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= !ex_is_load;
                            dmem_be    <= be_c;
                            dmem_addr  <= {ex_addr[ADDR_W-1:OFS_W], OFS_W'(0)};
                            dmem_wdata <= wdata_c;
                            ld_q       <= ex_is_load;
                            ld_f3_q    <= ex_funct3;
                            ld_ofs_q   <= ofs;
                        end else begin
                            wb_valid <= 1'b1;
                            misalign <= is_mem;
                        end
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        wb_valid <= 1'b1;
                        if (ld_q)
                            lmd <= ld_data_c;
                    end else if (tmo_hit) begin
                        dmem_req <= 1'b0;
                        wb_valid <= 1'b1;
                        bus_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;
    localparam int BE_W   = XLEN / 8;
`ifdef MEM_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              ex_valid = 1'b0;
    logic              ex_ready;
    logic              ex_is_load = 1'b0;
    logic              ex_is_store = 1'b0;
    logic [2:0]        ex_funct3 = '0;
    logic [ADDR_W-1:0] ex_addr = '0;
    logic [XLEN-1:0]   ex_wdata = '0;
    logic              ex_cond = 1'b0;
    logic [ADDR_W-1:0] ex_target = '0;
    logic [ADDR_W-1:0] ex_npc = '0;
    logic              dmem_req;
    logic              dmem_we;
    logic [BE_W-1:0]   dmem_be;
    logic [ADDR_W-1:0] dmem_addr;
    logic [XLEN-1:0]   dmem_wdata;
    logic [XLEN-1:0]   dmem_rdata = '0;
    logic              dmem_ack = 1'b0;
    logic              wb_valid;
    logic [XLEN-1:0]   lmd;
    logic [ADDR_W-1:0] condpc;
    logic              misalign;
    logic              bus_err;

    mem_stage_lsu #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_cond(ex_cond), .ex_target(ex_target), .ex_npc(ex_npc),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_valid(wb_valid), .lmd(lmd), .condpc(condpc),
        .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [XLEN-1:0]   exp_lmd    = '1;
    logic [ADDR_W-1:0] exp_condpc = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---- reference model ----
    function automatic int acc_bytes(logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit is_legal(bit ld, logic [2:0] f3);
        if (ld) return (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
                       (XLEN == 64 && f3 inside {3'd3, 3'd6});
        return (f3 inside {3'd0, 3'd1, 3'd2}) || (XLEN == 64 && f3 == 3'd3);
    endfunction

    function automatic logic [XLEN-1:0] model_load(logic [2:0] f3, logic [XLEN-1:0] rd, int ofs);
        int nb;
        logic [63:0] v, mask;
        nb   = 8 * acc_bytes(f3);
        v    = 64'(rd) >> (8 * ofs);
        mask = (nb >= 64) ? '1 : ((64'd1 << nb) - 64'd1);
        v    = v & mask;
        if (!f3[2] && v[nb-1]) v = v | ~mask;
        return v[XLEN-1:0];
    endfunction

    function automatic logic [XLEN-1:0] model_wdata(logic [2:0] f3, logic [XLEN-1:0] wd);
        logic [XLEN-1:0] o;
        int s;
        s = acc_bytes(f3);
        for (int i = 0; i < BE_W; i++) o[8*i +: 8] = wd[8*(i % s) +: 8];
        return o;
    endfunction

    function automatic logic [BE_W-1:0] model_be(logic [2:0] f3, int ofs);
        int m;
        m = ((1 << acc_bytes(f3)) - 1) << ofs;
        return m[BE_W-1:0];
    endfunction

    // Drive one op for a single accept cycle; returns #1 after the accept edge.
    task automatic issue(input bit ld, input bit st, input logic [2:0] f3,
                         input logic [ADDR_W-1:0] addr, input logic [XLEN-1:0] wd,
                         input bit cond, input logic [ADDR_W-1:0] tgt,
                         input logic [ADDR_W-1:0] npc);
        check("ready_idle", ex_ready, 1);
        ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
        ex_addr = addr; ex_wdata = wd; ex_cond = cond; ex_target = tgt; ex_npc = npc;
        step();
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
        exp_condpc = cond ? tgt : npc;
    endtask

    task automatic do_op(input bit ld, input bit st, input logic [2:0] f3,
                         input logic [ADDR_W-1:0] addr, input logic [XLEN-1:0] wd,
                         input logic [XLEN-1:0] rd, input bit cond,
                         input logic [ADDR_W-1:0] tgt, input logic [ADDR_W-1:0] npc,
                         input int waits);
        bit mem, mis;
        int ofs;
        ofs = int'(addr % BE_W);
        mem = ld || st;
        mis = mem && (!is_legal(ld, f3) || (addr % acc_bytes(f3)) != 0);
        issue(ld, st, f3, addr, wd, cond, tgt, npc);
        if (mem && !mis) begin
            check("req", dmem_req, 1);
            check("ready_busy", ex_ready, 0);
            check("we", dmem_we, !ld);
            check("addr", dmem_addr, addr - (addr % BE_W));
            check("be", dmem_be, model_be(f3, ofs));
            if (!ld) check("wdata", dmem_wdata, model_wdata(f3, wd));
            for (int w = 0; w < waits; w++) begin
                step();
                check("wait_nowb", wb_valid, 0);
                check("wait_req", dmem_req, 1);
            end
            dmem_ack = 1'b1; dmem_rdata = rd;
            step();
            dmem_ack = 1'b0;
            if (ld) exp_lmd = model_load(f3, rd, ofs);
            check("wb", wb_valid, 1);
            check("mis0", misalign, 0);
            check("berr0", bus_err, 0);
            check("req_drop", dmem_req, 0);
        end else begin
            check("wb", wb_valid, 1);
            check("mis", misalign, mis);
            check("nreq", dmem_req, 0);
        end
        check("lmd", lmd, exp_lmd);
        check("condpc", condpc, exp_condpc);
        step();
        check("wb_pulse", wb_valid, 0);
        check("ready_after", ex_ready, 1);
    endtask

    initial begin
        // Reset (active-high) held 3 cycles.
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_lmd", lmd, {XLEN{1'b1}});
        check("rst_wb", wb_valid, 0);
        check("rst_req", dmem_req, 0);
        check("rst_ready", ex_ready, 1);
        check("rst_condpc", condpc, 0);
        check("rst_be", dmem_be, 0);
        step();

        // Directed cases.
        do_op(1, 0, 3'b000, 32'h1003, '0, 32'h80FFFFFF, 0, 0, 32'h8, 2);
        check("lb_val", lmd, 32'hFFFFFF80);
        do_op(0, 1, 3'b001, 32'h2002, 32'h0000BEEF, '0, 0, 0, 32'hC, 1);
        do_op(1, 0, 3'b010, 32'h3001, '0, '0, 0, 0, 32'h10, 0);
        do_op(0, 0, 3'b000, '0, '0, '0, 1, 32'h400, 32'h104, 0);
        check("cond1", condpc, 32'h400);
        do_op(0, 0, 3'b000, '0, '0, '0, 0, 32'h400, 32'h104, 0);
        check("cond0", condpc, 32'h104);
        do_op(1, 0, 3'b100, 32'h44, '0, 32'h000000F0, 0, 0, 32'h14, 0);
        check("lbu_val", lmd, 32'h000000F0);
        do_op(1, 0, 3'b111, 32'h40, '0, '0, 0, 0, 32'h18, 0);

        // Ack while idle is ignored.
        dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
        step();
        dmem_ack = 1'b0;
        check("idle_ack_wb", wb_valid, 0);
        check("idle_ack_lmd", lmd, exp_lmd);

        // Randomized ops.
        for (int n = 0; n < 300; n++) begin
            int kind;
            logic [ADDR_W-1:0] a;
            kind = $urandom_range(0, 9);
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            do_op(kind < 4, kind >= 4 && kind < 8, 3'($urandom_range(0, 7)), a,
                  $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom, $urandom,
                  $urandom_range(0, 3));
        end

`ifdef MEM_TIMEOUT_EN
        // No ack: timeout after TMO BUSY cycles.
        issue(1, 0, 3'b010, 32'h80, '0, 0, 32'h0, 32'h20);
        check("tmo_req", dmem_req, 1);
        for (int c = 1; c < TMO; c++) begin
            step();
            check("tmo_wait", wb_valid, 0);
        end
        step();
        check("tmo_wb", wb_valid, 1);
        check("tmo_berr", bus_err, 1);
        check("tmo_req_drop", dmem_req, 0);
        check("tmo_lmd", lmd, exp_lmd);
        step();
        check("tmo_ready", ex_ready, 1);
        check("tmo_pulse", bus_err, 0);
`endif

        // Reset in the middle of BUSY, then a late ack.
        issue(1, 0, 3'b010, 32'h100, '0, 1, 32'h200, 32'h24);
        check("mr_req", dmem_req, 1);
        step();
        rst_n = 1'b1;
        #1;
        exp_lmd = '1;
        exp_condpc = '0;
        check("mr_req0", dmem_req, 0);
        check("mr_lmd", lmd, exp_lmd);
        check("mr_condpc", condpc, exp_condpc);
        check("mr_ready", ex_ready, 1);
        check("mr_be", dmem_be, 0);
        step();
        rst_n = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'hA5A5A5A5;
        step();
        dmem_ack = 1'b0;
        check("late_ack_wb", wb_valid, 0);
        check("late_ack_lmd", lmd, exp_lmd);
        do_op(1, 0, 3'b001, 32'h202, '0, 32'h7FFF0000, 0, 0, 32'h28, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
